dac_spi_tx: RTL and testbench
=============================

Name: dac_spi_tx

Overview:
- Serial transmitter feeding the external reservoir DAC. Sits directly downstream of the reservoir input path inside reservoir_asic.
- Accepts one DAC sample word plus a command byte per handshake and serialises it as an MSB-first SPI frame.
- Drives chip-select and SCLK, then pulses LDAC so the DAC output updates.
- Drives the top-level DAC_CS_N / DAC_LDAC_N / DAC_DIN / DAC_SCLK pins.

Parameters:
- CLK_DIV, 2, SCLK half-period in clk cycles (>=1); 2 gives 25 MHz SCLK at 100 MHz.
- DATA_WIDTH, 16, DAC sample width.
- CMD_WIDTH, 8, command prefix width; FRAME_WIDTH = CMD_WIDTH+DATA_WIDTH (default 24).
- LDAC_CYCLES, 2, LDAC_N low-pulse length in clk cycles (>=1).
- LDAC_EN, 1, 1 = pulse LDAC after each frame; 0 = LDAC_N held low, no LDAC state.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- din  in  DATA_WIDTH  sample to send
- cmd  in  CMD_WIDTH  command prefix, sent first
- start  in  1  request; accepted when start && ready
- ready  out  1  idle, can accept
- done  out  1  one-cycle pulse, frame plus LDAC complete
- DAC_CS_N  out  1  SPI chip select, active low
- DAC_LDAC_N  out  1  DAC load, active low
- DAC_DIN  out  1  serial data
- DAC_SCLK  out  1  serial clock, idle low

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high. All outputs are registered.
- Reset values: DAC_CS_N=1, DAC_SCLK=0, DAC_DIN=0, ready=1, done=0. DAC_LDAC_N=1 when LDAC_EN=1, 0 when LDAC_EN=0.
- Reset mid-frame aborts the frame. Outputs return to reset values on the next edge, with no partial LDAC pulse and no done.
- Acceptance (edge N): {cmd,din} is captured into the FRAME_WIDTH shift register. ready=0 from N+1. din/cmd are don't-care afterwards. start while ready=0 is ignored; there is no queueing.
- FSM: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> LDAC (skipped if LDAC_EN=0) -> IDLE.
- CS_SETUP: cycles N+1..N+CLK_DIV. CS_N=0, SCLK=0, DIN=frame MSB.
- SHIFT: FRAME_WIDTH bits. Each bit is SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles (CPOL=0). The DAC samples on the rising edge.
  - DIN changes only on the cycle SCLK goes low, never while high.
  - A bit counter counts down to 0. After the last high phase SCLK returns low.
- CS_HOLD: CLK_DIV cycles, CS_N=0, SCLK=0. CS_N rises at the end of this phase.
- LDAC: DAC_LDAC_N=0 for LDAC_CYCLES cycles with CS_N=1.
- Completion: on the next cycle done=1 and ready=1 together, and DIN returns to 0.
- Latency with defaults: CS_N low for cycles N+1..N+100, LDAC_N low N+101..N+102, done/ready at N+103.
  - General formula: done at N+1+2*CLK_DIV+2*FRAME_WIDTH*CLK_DIV+LDAC_CYCLES·LDAC_EN.
- Back-to-back: start high in the done cycle is accepted. The next CS_N falls the following cycle, giving a minimum CS_N high time of LDAC_CYCLES+1.
- Counters: a phase counter of width clog2(CLK_DIV+1) and a bit counter of width clog2(FRAME_WIDTH+1). Both wrap only by explicit reload; neither free-runs in IDLE.
- Elaboration: an illegal parameter (CLK_DIV<1, LDAC_CYCLES<1) fails via $error.

Decomposition:
- Package dfr_dac_pkg holds:
  - the state enum dac_tx_state_t (IDLE, CS_SETUP, SHIFT, CS_HOLD, LDAC);
  - the default widths;
  - DAC command constants: CMD_WRITE_UPDATE=8'h00, CMD_POWER_DOWN=8'h01.
- Sub-module sclk_phase_timer (CLK_DIV): load/count input, emits a one-cycle phase_end strobe. The FSM and shifter stay in dac_spi_tx.

Test Plan:
- Reset: hold rst 3 cycles mid-idle -> CS_N=1, SCLK=0, DIN=0, LDAC_N=1, ready=1, done=0.
- Single frame: cmd=8'h00, din=16'hA5C3, defaults.
  - Capture 24 rising-edge bits -> 24'h00A5C3, MSB first.
  - CS_N low exactly 100 cycles; SCLK high/low 2 cycles each; LDAC_N low 2 cycles after CS_N rises; done at N+103.
- DIN stability: random din, CLK_DIV=3 -> DIN never toggles while SCLK=1; exactly 24 SCLK rising edges per frame.
- Back-to-back: start held high, din=16'h0001 then 16'hFFFF.
  - Second frame accepted in the done cycle; CS_N high for 3 cycles between frames.
  - ready low during the frame; a start pulse at N+50 is ignored.
- Reset mid-frame: assert rst at N+40 -> all outputs at reset values the next cycle, no LDAC pulse, no done. A new frame 16'h1234 then sends correctly.
- LDAC_EN=0: LDAC_N constantly 0; done at N+101 with defaults.

Source files
------------

// File: rtl/dfr_dac_pkg.sv
// Shared definitions for the reservoir DAC serial transmitter.
//   dac_tx_state_t : transmitter FSM states
//   DEF_*          : default parameter values
//   CMD_*          : DAC command prefixes sent ahead of the sample word
//   frame_width()  : total bits in one SPI frame
package dfr_dac_pkg;

  localparam int DEF_CLK_DIV     = 2;
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_CMD_WIDTH   = 8;
  localparam int DEF_LDAC_CYCLES = 2;

  localparam logic [7:0] CMD_WRITE_UPDATE = 8'h00;
  localparam logic [7:0] CMD_POWER_DOWN   = 8'h01;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CS_HOLD  = 3'd3,
    LDAC     = 3'd4
  } dac_tx_state_t;

  function automatic int frame_width(input int cmd_w, input int data_w);
    return cmd_w + data_w;
  endfunction

endpackage

// File: rtl/dac_spi_tx_if.sv
// Request/handshake bundle between the reservoir input path and dac_spi_tx.
//   din   : sample word to send
//   cmd   : command prefix, sent first
//   start : request, taken when start && ready
//   ready : transmitter idle
//   done  : one-cycle pulse once frame and LDAC pulse are complete
// master = producer of samples, slave = the transmitter.
interface dac_spi_tx_if
  import dfr_dac_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CMD_WIDTH  = DEF_CMD_WIDTH
) ();

  logic [DATA_WIDTH-1:0] din;
  logic [CMD_WIDTH-1:0]  cmd;
  logic                  start;
  logic                  ready;
  logic                  done;

  modport master (
    output din,
    output cmd,
    output start,
    input  ready,
    input  done
  );

  modport slave (
    input  din,
    input  cmd,
    input  start,
    output ready,
    output done
  );

endinterface

// File: rtl/sclk_phase_timer.sv
// Phase timer for the SPI transmitter: measures CLK_DIV-cycle phases.
//   clk, rst    : system clock, synchronous active-high reset
//   load_i      : restart a phase (takes priority over count_i)
//   count_i     : a phase is running
//   phase_end_o : high during the last cycle of the running phase
// The counter only moves on load or while counting; it never wraps by itself.
module sclk_phase_timer
  import dfr_dac_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic count_i,
  output logic phase_end_o
);

  localparam int              CNT_W  = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] ZERO   = {CNT_W{1'b0}};

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("sclk_phase_timer: CLK_DIV must be >= 1");
  end

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A loaded phase lasts CLK_DIV cycles: reload to CLK_DIV-1, end when 0 is seen.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (count_i && (cnt_q != ZERO)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Phase counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_end_o = count_i && (cnt_q == ZERO);

endmodule

// File: rtl/dac_spi_tx.sv
// SPI transmitter for the external reservoir DAC.
//   clk, rst    : system clock, synchronous active-high reset
//   bus (slave) : din/cmd/start request, ready/done status
//   DAC_CS_N    : chip select, active low
//   DAC_LDAC_N  : DAC load strobe, active low (held low when LDAC_EN=0)
//   DAC_DIN     : serial data, MSB of {cmd,din} first
//   DAC_SCLK    : serial clock, idle low, DAC samples on its rising edge
// All pin and status outputs come straight from registers.
module dac_spi_tx
  import dfr_dac_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int CMD_WIDTH   = DEF_CMD_WIDTH,
  parameter int LDAC_CYCLES = DEF_LDAC_CYCLES,
  parameter int LDAC_EN     = 1
) (
  input  logic         clk,
  input  logic         rst,
  dac_spi_tx_if.slave  bus,
  output logic         DAC_CS_N,
  output logic         DAC_LDAC_N,
  output logic         DAC_DIN,
  output logic         DAC_SCLK
);

  localparam int FRAME_WIDTH = frame_width(CMD_WIDTH, DATA_WIDTH);
  localparam int BIT_W       = $clog2(FRAME_WIDTH + 1);
  localparam int LDAC_W      = $clog2(LDAC_CYCLES + 1);

  localparam logic [BIT_W-1:0]       BIT_LOAD    = BIT_W'(FRAME_WIDTH);
  localparam logic [LDAC_W-1:0]      LDAC_RELOAD = LDAC_W'(LDAC_CYCLES - 1);
  localparam logic [LDAC_W-1:0]      LDAC_ZERO   = {LDAC_W{1'b0}};
  localparam logic [FRAME_WIDTH-1:0] FRAME_ZERO  = {FRAME_WIDTH{1'b0}};
  // Level of LDAC_N whenever no load pulse is in progress.
  localparam logic                   LDAC_IDLE   = (LDAC_EN != 0) ? 1'b1 : 1'b0;

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("dac_spi_tx: CLK_DIV must be >= 1");
  end
  if (LDAC_CYCLES < 1) begin : g_bad_ldac
    $error("dac_spi_tx: LDAC_CYCLES must be >= 1");
  end

  dac_tx_state_t           state_q, state_d;
  logic [FRAME_WIDTH-1:0]  shift_q, shift_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [LDAC_W-1:0]       ldac_cnt_q, ldac_cnt_d;
  logic                    sclk_q, sclk_d;
  logic                    cs_n_q, cs_n_d;
  logic                    ldac_n_q, ldac_n_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;

  logic                    tmr_load_s;
  logic                    tmr_count_s;
  logic                    phase_end_s;

  sclk_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_timer (
    .clk         (clk),
    .rst         (rst),
    .load_i      (tmr_load_s),
    .count_i     (tmr_count_s),
    .phase_end_o (phase_end_s)
  );

  // Next-state and next-output logic for the transmit sequence.
  // DIN is the MSB of the shift register, so it only moves when the
  // register shifts, which happens only on a high->low SCLK transition.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    ldac_cnt_d  = ldac_cnt_q;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    ldac_n_d    = ldac_n_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    tmr_load_s  = 1'b0;
    tmr_count_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && ready_q) begin
          shift_d    = {bus.cmd, bus.din};
          bit_cnt_d  = BIT_LOAD;
          cs_n_d     = 1'b0;
          sclk_d     = 1'b0;
          ready_d    = 1'b0;
          tmr_load_s = 1'b1;
          state_d    = CS_SETUP;
        end else begin
          state_d = IDLE;
        end
      end

      CS_SETUP: begin
        tmr_count_s = 1'b1;
        if (phase_end_s) begin
          tmr_load_s = 1'b1;
          state_d    = SHIFT;
        end else begin
          state_d = CS_SETUP;
        end
      end

      SHIFT: begin
        tmr_count_s = 1'b1;
        if (phase_end_s && !sclk_q) begin
          // End of a low phase: rising edge, DAC samples DIN.
          sclk_d     = 1'b1;
          tmr_load_s = 1'b1;
        end else if (phase_end_s && sclk_q) begin
          // End of a high phase: bit finished.
          sclk_d     = 1'b0;
          tmr_load_s = 1'b1;
          bit_cnt_d  = bit_cnt_q - BIT_W'(1);
          if (bit_cnt_q == BIT_W'(1)) begin
            // Last bit keeps DIN steady through CS_HOLD.
            state_d = CS_HOLD;
          end else begin
            shift_d = {shift_q[FRAME_WIDTH-2:0], 1'b0};
          end
        end else begin
          sclk_d = sclk_q;
        end
      end

      CS_HOLD: begin
        tmr_count_s = 1'b1;
        if (phase_end_s) begin
          cs_n_d = 1'b1;
          if (LDAC_EN != 0) begin
            ldac_n_d   = 1'b0;
            ldac_cnt_d = LDAC_RELOAD;
            state_d    = LDAC;
          end else begin
            shift_d = FRAME_ZERO;
            done_d  = 1'b1;
            ready_d = 1'b1;
            state_d = IDLE;
          end
        end else begin
          state_d = CS_HOLD;
        end
      end

      LDAC: begin
        if (ldac_cnt_q == LDAC_ZERO) begin
          ldac_n_d = 1'b1;
          shift_d  = FRAME_ZERO;
          done_d   = 1'b1;
          ready_d  = 1'b1;
          state_d  = IDLE;
        end else begin
          ldac_cnt_d = ldac_cnt_q - LDAC_W'(1);
        end
      end

      default: begin
        state_d  = IDLE;
        shift_d  = FRAME_ZERO;
        sclk_d   = 1'b0;
        cs_n_d   = 1'b1;
        ldac_n_d = LDAC_IDLE;
        ready_d  = 1'b1;
      end
    endcase
  end

  // State and output registers; reset also aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= FRAME_ZERO;
      bit_cnt_q  <= {BIT_W{1'b0}};
      ldac_cnt_q <= LDAC_ZERO;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      ldac_n_q   <= LDAC_IDLE;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      ldac_cnt_q <= ldac_cnt_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      ldac_n_q   <= ldac_n_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  assign bus.ready  = ready_q;
  assign bus.done   = done_q;
  assign DAC_CS_N   = cs_n_q;
  assign DAC_LDAC_N = ldac_n_q;
  assign DAC_DIN    = shift_q[FRAME_WIDTH-1];
  assign DAC_SCLK   = sclk_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Testbench for dac_spi_tx. Three instances share one clock and reset:
//   0: defaults (CLK_DIV=2, LDAC_CYCLES=2, LDAC_EN=1)
//   1: CLK_DIV=3, LDAC_CYCLES=1, LDAC_EN=1
//   2: defaults with LDAC_EN=0
// One instance at a time is driven; its pins are watched cycle by cycle and
// reduced to frame contents, timing figures and counts of rule violations.
module tb_dac_spi_tx;
  import dfr_dac_pkg::*;

  localparam int FW = 24;

  int cd_tab [3] = '{2, 3, 2};
  int lc_tab [3] = '{2, 1, 2};
  int en_tab [3] = '{1, 1, 0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int          sel     = 0;
  logic        start_v = 1'b0;
  logic [15:0] din_v   = 16'h0000;
  logic [7:0]  cmd_v   = 8'h00;

  dac_spi_tx_if #(.DATA_WIDTH(16), .CMD_WIDTH(8)) a_if ();
  dac_spi_tx_if #(.DATA_WIDTH(16), .CMD_WIDTH(8)) b_if ();
  dac_spi_tx_if #(.DATA_WIDTH(16), .CMD_WIDTH(8)) c_if ();

  logic cs_w [3];
  logic ld_w [3];
  logic dn_w [3];
  logic sk_w [3];
  logic rd_w [3];
  logic dd_w [3];

  assign a_if.start = start_v && (sel == 0);
  assign b_if.start = start_v && (sel == 1);
  assign c_if.start = start_v && (sel == 2);
  assign a_if.din = din_v;  assign a_if.cmd = cmd_v;
  assign b_if.din = din_v;  assign b_if.cmd = cmd_v;
  assign c_if.din = din_v;  assign c_if.cmd = cmd_v;
  assign rd_w[0] = a_if.ready;  assign dd_w[0] = a_if.done;
  assign rd_w[1] = b_if.ready;  assign dd_w[1] = b_if.done;
  assign rd_w[2] = c_if.ready;  assign dd_w[2] = c_if.done;

  dac_spi_tx #(.CLK_DIV(2), .DATA_WIDTH(16), .CMD_WIDTH(8), .LDAC_CYCLES(2), .LDAC_EN(1)) u_a (
    .clk(clk), .rst(rst), .bus(a_if),
    .DAC_CS_N(cs_w[0]), .DAC_LDAC_N(ld_w[0]), .DAC_DIN(dn_w[0]), .DAC_SCLK(sk_w[0]));
  dac_spi_tx #(.CLK_DIV(3), .DATA_WIDTH(16), .CMD_WIDTH(8), .LDAC_CYCLES(1), .LDAC_EN(1)) u_b (
    .clk(clk), .rst(rst), .bus(b_if),
    .DAC_CS_N(cs_w[1]), .DAC_LDAC_N(ld_w[1]), .DAC_DIN(dn_w[1]), .DAC_SCLK(sk_w[1]));
  dac_spi_tx #(.CLK_DIV(2), .DATA_WIDTH(16), .CMD_WIDTH(8), .LDAC_CYCLES(2), .LDAC_EN(0)) u_c (
    .clk(clk), .rst(rst), .bus(c_if),
    .DAC_CS_N(cs_w[2]), .DAC_LDAC_N(ld_w[2]), .DAC_DIN(dn_w[2]), .DAC_SCLK(sk_w[2]));

  logic m_cs_n, m_ldac_n, m_din, m_sclk, m_ready, m_done;
  always_comb begin
    m_cs_n   = cs_w[sel];
    m_ldac_n = ld_w[sel];
    m_din    = dn_w[sel];
    m_sclk   = sk_w[sel];
    m_ready  = rd_w[sel];
    m_done   = dd_w[sel];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (dut %0d): actual=%0h required=%0h", name, sel, act, exp);
    end
  endtask

  // Reference timing: setup + FW bits of two phases + hold, then LDAC pulse.
  function automatic int model_done(input int s);
    return 1 + 2 * cd_tab[s] * (FW + 1) + lc_tab[s] * en_tab[s];
  endfunction

  // Issue one request on instance s (call just after a negedge) and watch the
  // frame until done or a cycle budget expires. hold keeps start high so the
  // next call is accepted back-to-back; ign>0 pulses start at cycle N+ign.
  task automatic run_frame(input int s, input logic [7:0] c, input logic [15:0] d,
                           input bit hold, input int ign,
                           input logic [23:0] exp_frame, input int exp_done);
    int k = 0, cd, lc, en;
    int rises = 0, falls = 0, run = 0, bad_runs = 0, sclk_hi = 0, din_hi_tog = 0;
    int cs_lo = 0, cs_first = 0, cs_last = 0, cs_tail = 0, sclk_cs_bad = 0;
    int ldac_lo = 0, ldac_first = 0, rdy_lo = 0, done_at = 0;
    logic din_at_done = 1'b1;
    logic sclk_prev = 1'b0, din_prev = 1'b0;
    logic [23:0] cap = 24'h000000;
    cd = cd_tab[s]; lc = lc_tab[s]; en = en_tab[s];
    sel = s; cmd_v = c; din_v = d; start_v = 1'b1;
    #1;
    check("ready_before_start", m_ready, 1'b1);
    @(posedge clk);
    while (done_at == 0 && k < exp_done + 8) begin
      @(negedge clk);
      k++;
      if (k == 1 && !hold) start_v = 1'b0;
      if (ign > 0 && k == ign) begin start_v = 1'b1; din_v = 16'($urandom); end
      if (ign > 0 && k == ign + 1 && !hold) start_v = 1'b0;
      if (!m_cs_n) begin
        cs_lo++;
        if (cs_first == 0) cs_first = k;
        cs_last = k;
      end else if (cs_last > 0) begin
        cs_tail++;
      end
      if (m_cs_n && m_sclk) sclk_cs_bad++;
      if (m_sclk) sclk_hi++;
      if (m_sclk && !sclk_prev) begin
        rises++;
        cap = {cap[22:0], m_din};
        if (falls > 0 && run != cd) bad_runs++;
        run = 1;
      end else if (!m_sclk && sclk_prev) begin
        falls++;
        if (run != cd) bad_runs++;
        run = 1;
      end else begin
        run++;
      end
      if (m_sclk && sclk_prev && (m_din !== din_prev)) din_hi_tog++;
      if (!m_ldac_n) begin
        ldac_lo++;
        if (ldac_first == 0) ldac_first = k;
      end
      if (!m_ready) rdy_lo++;
      if (m_done) begin done_at = k; din_at_done = m_din; end
      sclk_prev = m_sclk;
      din_prev  = m_din;
    end
    check("frame_bits", cap, exp_frame);
    check("sclk_rising_edges", rises, FW);
    check("din_toggle_while_sclk_high", din_hi_tog, 0);
    check("sclk_phase_length", bad_runs, 0);
    check("sclk_high_cycles", sclk_hi, FW * cd);
    check("sclk_while_cs_high", sclk_cs_bad, 0);
    check("cs_fall_cycle", cs_first, 1);
    check("cs_low_cycles", cs_lo, 2 * cd * (FW + 1));
    check("cs_low_contiguous", cs_last, 2 * cd * (FW + 1));
    if (en != 0) begin
      check("ldac_low_cycles", ldac_lo, lc);
      check("ldac_first_cycle", ldac_first, 2 * cd * (FW + 1) + 1);
    end else begin
      check("ldac_held_low", ldac_lo, k);
    end
    check("done_cycle", done_at, exp_done);
    check("ready_low_cycles", rdy_lo, exp_done - 1);
    check("din_zero_at_done", din_at_done, 1'b0);
    check("cs_high_before_done", cs_tail, lc * en + 1);
  endtask

  typedef struct {
    int          s;
    logic [7:0]  c;
    logic [15:0] d;
    int          ign;
    logic [23:0] exp_frame;
    int          exp_done;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int n_ld, n_dn, n_cs;
    logic [7:0]  rc;
    logic [15:0] rd;
    int rs, rign;

    vecs[0] = '{0, 8'h00, 16'hA5C3, 0,  24'h00A5C3, 103};
    vecs[1] = '{0, 8'h01, 16'h8001, 50, 24'h018001, 103};
    vecs[2] = '{1, 8'h00, 16'h5A3C, 0,  24'h005A3C, 152};
    vecs[3] = '{2, 8'h00, 16'hA5C3, 0,  24'h00A5C3, 101};
    vecs[4] = '{2, 8'hFF, 16'h0000, 20, 24'hFF0000, 101};

    // Reset held three cycles, outputs checked on every instance.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("reset_outputs", {m_cs_n, m_sclk, m_din, m_ldac_n, m_ready, m_done},
            {1'b1, 1'b0, 1'b0, (en_tab[s] != 0), 1'b1, 1'b0});
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors.
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].s, vecs[i].c, vecs[i].d, 1'b0, vecs[i].ign,
                vecs[i].exp_frame, vecs[i].exp_done);
      repeat (2) @(negedge clk);
    end

    // Back-to-back: start held, second frame taken in the done cycle.
    run_frame(0, CMD_WRITE_UPDATE, 16'h0001, 1'b1, 0, 24'h000001, 103);
    run_frame(0, CMD_WRITE_UPDATE, 16'hFFFF, 1'b0, 0, 24'h00FFFF, 103);
    repeat (2) @(negedge clk);

    // Reset mid-frame at N+40, then confirm no LDAC pulse and no done.
    sel = 0; cmd_v = 8'h00; din_v = 16'hBEEF; start_v = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) start_v = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_reset_outputs", {m_cs_n, m_sclk, m_din, m_ldac_n, m_ready, m_done},
          6'b100110);
    n_ld = 0; n_dn = 0; n_cs = 0;
    for (int k = 0; k < 120; k++) begin
      if (k == 2) rst = 1'b0;
      @(negedge clk);
      if (!m_ldac_n) n_ld++;
      if (m_done) n_dn++;
      if (!m_cs_n) n_cs++;
    end
    check("abort_no_ldac", n_ld, 0);
    check("abort_no_done", n_dn, 0);
    check("abort_cs_stays_high", n_cs, 0);
    run_frame(0, 8'h00, 16'h1234, 1'b0, 0, 24'h001234, 103);
    repeat (2) @(negedge clk);

    // Randomised frames against the reference model.
    for (int i = 0; i < 9; i++) begin
      rs   = $urandom_range(0, 2);
      rc   = ($urandom_range(0, 1) == 1) ? CMD_POWER_DOWN : 8'($urandom);
      rd   = 16'($urandom);
      rign = ($urandom_range(0, 1) == 1) ? $urandom_range(5, 60) : 0;
      run_frame(rs, rc, rd, 1'b0, rign, {rc, rd}, model_done(rs));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
